// File: rtl/tot_fine_encoder_pkg.sv
// Shared constants and bubble-status encodings for the TOT fine-phase encoder.
package tot_fine_encoder_pkg;

  localparam int TOT_CODE_W  = 21;
  localparam int TOT_BIN_W   = 6;
  localparam int TOT_NSTATES = 42;

  typedef enum logic [1:0] {
    BUB_NONE = 2'b00,
    BUB_OK   = 2'b01,
    BUB_FAIL = 2'b11
  } bubble_e;

endpackage

// File: rtl/tot_popcount21.sv
// Combinational population count of a 21-bit word, built as a shallow adder tree.
module tot_popcount21
  import tot_fine_encoder_pkg::*;
(
  input  logic [TOT_CODE_W-1:0] code_i,
  output logic [4:0]            count_o
);

  logic [1:0] tripleSum [7];
  logic [2:0] pairSum [3];
  logic [3:0] quadSum;

  // First level: seven 3-bit groups, each summing to at most 3.
  for (genvar g = 0; g < 7; g++) begin : gTriple
    assign tripleSum[g] = {1'b0, code_i[3*g]} + {1'b0, code_i[3*g+1]} + {1'b0, code_i[3*g+2]};
  end

  for (genvar g = 0; g < 3; g++) begin : gPair
    assign pairSum[g] = {1'b0, tripleSum[2*g]} + {1'b0, tripleSum[2*g+1]};
  end

  assign quadSum = {1'b0, pairSum[0]} + {1'b0, pairSum[1]};
  assign count_o = {1'b0, quadSum} + {2'b00, pairSum[2]} + {3'b000, tripleSum[6]};

endmodule

// File: rtl/tot_fine_encoder.sv
// Registered thermometer-to-binary fine-phase encoder for the TOT path with
// bubble detection against a programmable tolerance.
module tot_fine_encoder
  import tot_fine_encoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TOT_CODE_W-1:0] encode_In,
  input  logic [1:0]            level,
  output logic [TOT_BIN_W-1:0]  Binary_Out,
  output logic [1:0]            bubbleError
);

  logic [4:0]            onesCount;
  logic [4:0]            edgeCount;
  logic [TOT_CODE_W-1:0] edgeVec;
  logic [4:0]            extraEdges;
  logic [2:0]            tolerance;

  logic [TOT_BIN_W-1:0]  binOut_d, binOut_q;
  bubble_e               bubErr_d, bubErr_q;

  // Each set bit marks a tap whose value differs from the tap below it.
  assign edgeVec = {1'b0, encode_In[TOT_CODE_W-1:1] ^ encode_In[TOT_CODE_W-2:0]};

  tot_popcount21 uOnes (
    .code_i  (encode_In),
    .count_o (onesCount)
  );

  tot_popcount21 uEdges (
    .code_i  (edgeVec),
    .count_o (edgeCount)
  );

  always_comb begin
    binOut_d   = {1'b0, onesCount};
    bubErr_d   = BUB_NONE;
    extraEdges = (edgeCount == 5'd0) ? 5'd0 : edgeCount - 5'd1;
    tolerance  = (level == 2'd0) ? 3'd2 : {level, 1'b0};

    // Second half of the ring counts downward in ones; all-ones stays at 21.
    if (encode_In[TOT_CODE_W-1] && (onesCount != 5'd21)) begin
      binOut_d = TOT_BIN_W'(TOT_NSTATES) - {1'b0, onesCount};
    end

    if (extraEdges == 5'd0) begin
      bubErr_d = BUB_NONE;
    end else if (extraEdges > {2'b00, tolerance}) begin
      bubErr_d = BUB_FAIL;
    end else begin
      bubErr_d = BUB_OK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      binOut_q <= '0;
      bubErr_q <= BUB_NONE;
    end else begin
      binOut_q <= binOut_d;
      bubErr_q <= bubErr_d;
    end
  end

  assign Binary_Out  = binOut_q;
  assign bubbleError = bubErr_q;

endmodule

// File: tb/tb_tot_fine_encoder.sv
// Self-checking bench for tot_fine_encoder: directed test-plan steps, a ring
// sweep, and randomized codes scored against a popcount/transition model.
module tb_tot_fine_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] encode_In;
  logic [1:0]  level;
  logic [5:0]  Binary_Out;
  logic [1:0]  bubbleError;

  int passCount = 0;
  int checkCount = 0;

  tot_fine_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .encode_In   (encode_In),
    .level       (level),
    .Binary_Out  (Binary_Out),
    .bubbleError (bubbleError)
  );

  always #5 clk = ~clk;

  // Reference: count ones and tap-to-tap transitions directly from the code.
  task automatic refModel(input logic [20:0] c, input logic [1:0] lv,
                          output logic [5:0] expBin, output logic [1:0] expErr);
    int n, t, lim, extra;
    n = 0;
    t = 0;
    for (int i = 0; i < 21; i++) if (c[i]) n++;
    for (int i = 1; i < 21; i++) if (c[i] != c[i-1]) t++;
    if (!c[20]) expBin = 6'(n);
    else if (n == 21) expBin = 6'd21;
    else expBin = 6'(42 - n);
    lim = (lv == 2'd0) ? 2 : 2 * int'(lv);
    extra = (t >= 1) ? t - 1 : 0;
    if (extra == 0) expErr = 2'b00;
    else if (extra <= lim) expErr = 2'b01;
    else expErr = 2'b11;
  endtask

  function automatic logic [20:0] ringCode(input int p);
    logic [20:0] mask;
    if (p <= 20) begin
      mask = (21'd1 << p) - 21'd1;
      return mask;
    end
    mask = (21'd1 << (p - 21)) - 21'd1;
    return ~mask;
  endfunction

  task automatic applyStimulus(input logic [20:0] code, input logic [1:0] lv);
    encode_In = code;
    level     = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] expBin, input logic [1:0] expErr);
    checkCount++;
    assert (Binary_Out === expBin) passCount++;
    else $error("[TB] FAIL %s Binary_Out got %0d expected %0d", tag, Binary_Out, expBin);
    checkCount++;
    assert (bubbleError === expErr) passCount++;
    else $error("[TB] FAIL %s bubbleError got %b expected %b", tag, bubbleError, expErr);
  endtask

  initial begin
    logic [20:0] c;
    logic [1:0]  lv;
    logic [5:0]  mBin;
    logic [1:0]  mErr;

    reset     = 1'b1;
    encode_In = 21'h1FFFFF;
    level     = 2'd1;

    applyStimulus(21'h1FFFFF, 2'd1);
    checkOutput("reset0", 6'd0, 2'b00);
    applyStimulus(21'h1FFFFF, 2'd1);
    checkOutput("reset1", 6'd0, 2'b00);
    reset = 1'b0;
    applyStimulus(21'h1FFFFF, 2'd1);
    checkOutput("postReset", 6'd21, 2'b00);

    applyStimulus(21'h00001F, 2'd1);
    checkOutput("phaseA5", 6'd5, 2'b00);
    applyStimulus(21'h000000, 2'd1);
    checkOutput("phaseA0", 6'd0, 2'b00);
    applyStimulus(21'h1FFFF8, 2'd1);
    checkOutput("phaseB24", 6'd24, 2'b00);
    applyStimulus(21'h100000, 2'd1);
    checkOutput("phaseB41", 6'd41, 2'b00);
    applyStimulus(21'h1FFFFF, 2'd1);
    checkOutput("phaseB21", 6'd21, 2'b00);

    applyStimulus(21'h00002F, 2'd1);
    checkOutput("bubbleLvl1", 6'd5, 2'b01);
    applyStimulus(21'h00002F, 2'd0);
    checkOutput("bubbleLvl0", 6'd5, 2'b01);
    applyStimulus(21'b1_0101_0101_0101_0101_0101, 2'd3);
    checkOutput("bubbleFail", 6'd31, 2'b11);
    // E=4 exceeds level-1 tolerance (2) but not level-2 tolerance (4).
    applyStimulus(21'h0000AF, 2'd1);
    checkOutput("tolEdgeL1", 6'd6, 2'b11);
    applyStimulus(21'h0000AF, 2'd2);
    checkOutput("tolEdgeL2", 6'd6, 2'b01);

    for (int p = 0; p < 42; p++) begin
      applyStimulus(ringCode(p), 2'($urandom_range(0, 3)));
      checkOutput($sformatf("ring%0d", p), 6'(p), 2'b00);
    end
    applyStimulus(21'h000000, 2'd1);
    checkOutput("ringWrap", 6'd0, 2'b00);

    for (int k = 0; k < 200; k++) begin
      lv = 2'($urandom_range(0, 3));
      if (k % 2 == 0) begin
        c = 21'($urandom) & 21'h1FFFFF;
      end else begin
        c = ringCode($urandom_range(0, 41));
        c = c ^ (21'd1 << $urandom_range(0, 20));
        if (k % 4 == 1) c = c ^ (21'd1 << $urandom_range(0, 20));
      end
      refModel(c, lv, mBin, mErr);
      applyStimulus(c, lv);
      checkOutput($sformatf("rand%0d", k), mBin, mErr);
    end

    reset = 1'b1;
    applyStimulus(21'h0F0F0F, 2'd2);
    checkOutput("resetAgain", 6'd0, 2'b00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/tot_fine_encoder.md
# tot_fine_encoder

Registered fine-phase encoder for the ETROC2 TDC TOT path. Converts the 21-bit circular thermometer code sampled from the TOT delay line into a 6-bit binary fine phase (0..41). Flags bubbles in the code against a programmable tolerance level. Sits between the TOT sample DFFs and the TOT code combiner/readout.

## Interface
- No parameters. Widths are fixed: code 21 bits, output 6 bits, 42 phase states.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- encode_In  input  21  raw thermometer code from the TOT sample DFFs; bit 0 is the first tap.
- level  input  2  bubble tolerance; valid values 1..3, and 0 is treated as 1.
- Binary_Out  output  6  encoded fine phase, 0..41.
- bubbleError  output  2  bubble status for the code encoded into the current Binary_Out.

## Operation
- Valid codes form a 42-state ring:
  - Phase A, encode_In[20]=0: the low k bits are 1 and the rest are 0, k=0..20.
  - Phase B, encode_In[20]=1: the low k bits are 0 and the rest are 1, k=0..20. k=0 is all-ones.
- N = popcount(encode_In), range 0..21.
- Binary mapping:
  - If encode_In[20]=0: Binary = N.
  - If encode_In[20]=1: Binary = 21 when N=21, else 42−N.
  - Ideal codes therefore map monotonically: all-zeros→0, 5 low ones→5, all-ones→21, 1 low zero→22, 20 low zeros→41.
- Bubbles are corrected implicitly by the popcount. No separate correction is applied.
- T = number of i in 1..20 with encode_In[i] ≠ encode_In[i−1]. Ideal codes have T ≤ 1.
- L = level, with 0 mapped to 1. Extra transitions E = T−1 when T ≥ 1, else 0.
- bubbleError:
  - 2'b00 if E=0 (clean).
  - 2'b01 if 0 < E ≤ 2·L (bubble within tolerance; output trusted).
  - 2'b11 if E > 2·L (uncorrectable; output still the popcount mapping).
  - 2'b10 is never produced.
- level is used combinationally together with encode_In in the same cycle.

## Timing
- One-cycle latency. Inputs are sampled at rising edge n; Binary_Out and bubbleError reflect them from edge n until edge n+1.
- Outputs are registered. There is no combinational path from inputs to outputs.
- Reset:
  - While reset=1 at an edge, Binary_Out=0 and bubbleError=2'b00. Reset overrides any input.
  - The first valid output appears at the edge after reset deasserts (the edge that samples with reset=0).
- A new code is accepted every cycle. No handshake and no stall.
- Wrap-around: the transition 41 → 0 (20 low zeros → all zeros) is just another input. There is no state across cycles other than the output registers.
- A change of level mid-stream affects only the code sampled at the same edge.

## Structure
- Shared package holds:
  - constants TOT_CODE_W=21, TOT_BIN_W=6, TOT_NSTATES=42;
  - the bubbleError encodings BUB_NONE=2'b00, BUB_OK=2'b01, BUB_FAIL=2'b11.
- One natural sub-module, tot_popcount21: a combinational 21-bit population count producing 5 bits. Adder tree is preferred.
- Transition counting and the mapping logic live in the top.

## Test plan
- Reset: assert reset for 2 cycles with encode_In=21'h1FFFFF. Required: Binary_Out=0 and bubbleError=00 throughout. After release, the next edge gives 21/00.
- Phase A: encode_In=21'h00001F, level=1. Required: Binary_Out=5 and bubbleError=00 one cycle later. For 21'h000000, required 0/00.
- Phase B: encode_In=21'h1FFFF8 (N=18). Required: 24/00. For 21'h100000, required 41/00. For 21'h1FFFFF, required 21/00.
- Correctable bubble: encode_In=21'h00002F with level=1 (N=5, T=3, E=2). Required: Binary_Out=5, bubbleError=01. Same code with level=0: required 5/01.
- Uncorrectable bubble: encode_In=21'b1_0101_0101_0101_0101_0101 with level=3 (N=11, T=20, E=19). Required: Binary_Out=31, bubbleError=11.
- Ring sweep: apply all 42 ideal codes in ring order back-to-back, one per cycle, then wrap to all-zeros. Required:
  - Binary_Out steps 0,1,…,41,0 with one-cycle lag;
  - bubbleError=00 on every cycle.
